// File: rtl/clock_rate_selector.sv
// Four-rate CPU timing generator: one-cycle tick enable plus legacy square clock, with
// boundary-only rate switching, pause and single-step. Optional tick counter: CLOCK_RATE_SELECTOR_TICK_COUNT_EN.
module clock_rate_selector #(
    parameter int unsigned   CNT_W = 32,
    parameter logic [CNT_W-1:0] DIV0 = CNT_W'(1),
    parameter logic [CNT_W-1:0] DIV1 = CNT_W'(1000),
    parameter logic [CNT_W-1:0] DIV2 = CNT_W'(100000),
    parameter logic [CNT_W-1:0] DIV3 = CNT_W'(1000000)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel,
    input  logic        pause,
    input  logic        step,
    output logic        tick,
    output logic        clk_out,
    output logic [1:0]  cur_sel,
    output logic [31:0] tick_count
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic             step_q;

    logic [CNT_W-1:0] div_raw;
    logic [CNT_W-1:0] div_eff;
    logic             term;
    logic             step_edge;

    always_comb begin
        div_raw = DIV0;
        case (cur_sel_q)
            2'd0:    div_raw = DIV0;
            2'd1:    div_raw = DIV1;
            2'd2:    div_raw = DIV2;
            default: div_raw = DIV3;
        endcase
    end

    assign div_eff   = (div_raw == '0) ? CNT_W'(1) : div_raw;
    // >= so a count held across a paused rate change to a shorter divisor still terminates
    assign term      = (cnt_q >= div_eff - CNT_W'(1));
    assign step_edge = step & ~step_q;

    always_comb begin
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        cur_sel_d = cur_sel_q;
        if (pause) begin
            cur_sel_d = sel;
            if (step_edge) begin
                tick_d    = 1'b1;
                clk_out_d = ~clk_out_q;
                cnt_d     = '0;
            end
        end else if (term) begin
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
            cnt_d     = '0;
            cur_sel_d = sel;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            cur_sel_q <= 2'd0;
            step_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            cur_sel_q <= cur_sel_d;
            step_q    <= step;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;
    assign cur_sel = cur_sel_q;

`ifdef CLOCK_RATE_SELECTOR_TICK_COUNT_EN
    logic [31:0] tick_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_count_q <= '0;
        end else if (tick_q) begin
            tick_count_q <= tick_count_q + 32'd1;
        end
    end

    assign tick_count = tick_count_q;
`else
    assign tick_count = '0;
`endif

endmodule

// File: tb/tb_clock_rate_selector.sv
// Directed bench for clock_rate_selector with DIV0=1, DIV1=3, DIV2=5, DIV3=0.
module tb_clock_rate_selector;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        pause;
    logic        step;
    logic        tick;
    logic        clk_out;
    logic [1:0]  cur_sel;
    logic [31:0] tick_count;

    always #5 clk = ~clk;

    clock_rate_selector #(
        .CNT_W (32),
        .DIV0  (32'd1),
        .DIV1  (32'd3),
        .DIV2  (32'd5),
        .DIV3  (32'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .pause      (pause),
        .step       (step),
        .tick       (tick),
        .clk_out    (clk_out),
        .cur_sel    (cur_sel),
        .tick_count (tick_count)
    );

`ifdef CLOCK_RATE_SELECTOR_TICK_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic        exp_clk;
    logic        last_tick;
    logic [31:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_model();
        return CntEn ? exp_cnt : 32'd0;
    endfunction

    // One clock; tick_count lags tick by a cycle, so it advances on the previous expected tick.
    task automatic cyc(input logic exp_tick, input string tag);
        @(posedge clk);
        #1;
        if (last_tick) exp_cnt++;
        check({tag, "/tick"}, 32'(tick), 32'(exp_tick));
        if (exp_tick) exp_clk = ~exp_clk;
        check({tag, "/clk_out"}, 32'(clk_out), 32'(exp_clk));
        check({tag, "/tick_count"}, tick_count, cnt_model());
        last_tick = exp_tick;
    endtask

    // Starting just after a tick, expect one tick every 'period' cycles.
    task automatic run(input int n, input int period, input string tag);
        for (int i = 1; i <= n; i++) begin
            cyc((i % period) == 0, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "/rst_tick"}, 32'(tick), 32'd0);
        check({tag, "/rst_clk_out"}, 32'(clk_out), 32'd0);
        check({tag, "/rst_cur_sel"}, 32'(cur_sel), 32'd0);
        check({tag, "/rst_tick_count"}, tick_count, 32'd0);
        rst       = 1'b0;
        exp_clk   = 1'b0;
        exp_cnt   = 32'd0;
        last_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 2'd0; pause = 1'b0; step = 1'b0;
        exp_clk = 1'b0; exp_cnt = 32'd0; last_tick = 1'b0;

        // 1: divide-by-1 after reset
        do_reset("t1");
        run(6, 1, "t1");
        check("t1/cur_sel", 32'(cur_sel), 32'd0);

        // 2: switch to sel=1 at the next boundary, then every 3rd cycle
        sel = 2'd1;
        cyc(1'b1, "t2sw");
        check("t2/cur_sel", 32'(cur_sel), 32'd1);
        run(9, 3, "t2");

        // 3: reach sel=2, then request sel=1 two cycles into a period
        sel = 2'd2;
        run(3, 3, "t3a");
        check("t3/cur_sel2", 32'(cur_sel), 32'd2);
        run(5, 5, "t3b");
        cyc(1'b0, "t3c");
        cyc(1'b0, "t3c");
        sel = 2'd1;
        cyc(1'b0, "t3c");
        cyc(1'b0, "t3c");
        check("t3/cur_sel_hold", 32'(cur_sel), 32'd2);
        cyc(1'b1, "t3c");
        check("t3/cur_sel1", 32'(cur_sel), 32'd1);
        run(6, 3, "t3d");

        // 4: pause at cnt=2 of a sel=2 period, single-step, resume
        sel = 2'd2;
        run(3, 3, "t4a");
        check("t4/cur_sel", 32'(cur_sel), 32'd2);
        cyc(1'b0, "t4b");
        cyc(1'b0, "t4b");
        pause = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b0, "t4pause");
        step = 1'b1;
        cyc(1'b1, "t4step");
        for (int i = 0; i < 3; i++) cyc(1'b0, "t4hold");
        step  = 1'b0;
        pause = 1'b0;
        run(5, 5, "t4resume");

        // 5: DIV3=0 acts as divide-by-1, then reset mid-stream
        sel = 2'd3;
        run(5, 5, "t5a");
        check("t5/cur_sel", 32'(cur_sel), 32'd3);
        run(4, 1, "t5b");
        do_reset("t5");

        // 6: tick counter over 10 ticks, then cleared by reset
        sel = 2'd0;
        run(11, 1, "t6");
        check("t6/tick_count10", tick_count, CntEn ? 32'd10 : 32'd0);
        do_reset("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
